// File: rtl/axi_dma_wr_mc.sv
// AXI4 write-DMA master: splits a block of beats into INCR bursts and keeps
// several of them in flight at once, with the AW and W channels decoupled.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_CALC  | compute the next burst length; hold here while outstanding is full
// S_ISSUE | AWVALID asserted, waiting for AWREADY
// S_DRAIN | all AW issued; wait for W and B to finish
module axi_dma_wr_mc #(
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 32,
  parameter int ID_W            = 4,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 20,
  parameter int AXI_ID          = 0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [CNT_W-1:0]    num_trans,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ID_W-1:0]     M_AWID,
  output logic [ADDR_W-1:0]   M_AWADDR,
  output logic [7:0]          M_AWLEN,
  output logic [2:0]          M_AWSIZE,
  output logic [1:0]          M_AWBURST,
  output logic [3:0]          M_AWCACHE,
  output logic [2:0]          M_AWPROT,
  output logic [3:0]          M_AWQOS,
  output logic                M_AWVALID,
  input  logic                M_AWREADY,
  output logic [DATA_W-1:0]   M_WDATA,
  output logic [DATA_W/8-1:0] M_WSTRB,
  output logic                M_WLAST,
  output logic                M_WVALID,
  input  logic                M_WREADY,
  input  logic [ID_W-1:0]     M_BID,
  input  logic [1:0]          M_BRESP,
  input  logic                M_BVALID,
  output logic                M_BREADY
);
  localparam int SZ = $clog2(DATA_W/8);
  localparam int LW = 9;
  localparam int RW = CNT_W + 1;
  localparam int MW = (RW > 13) ? RW : 13;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [RW-1:0]     remaining;
  logic [LW-1:0]     len;
  logic [LW-1:0]     len_calc;
  logic [OW-1:0]     outstanding;
  logic [7:0]        fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [OW-1:0]     fifo_cnt;
  logic [7:0]        beat_cnt;
  logic              aw_hs, w_hs, b_hs, pop, fifo_empty;
  logic [MW-1:0]     cand, bnd;
  logic              unused_bid;

  assign M_AWID     = ID_W'(AXI_ID);
  assign M_AWSIZE   = 3'(SZ);
  assign M_AWBURST  = 2'b01;
  assign M_AWCACHE  = 4'b0011;
  assign M_AWPROT   = 3'b000;
  assign M_AWQOS    = 4'hF;
  assign M_WSTRB    = '1;
  assign M_WDATA    = s_data;
  assign M_AWADDR   = addr;
  assign M_BREADY   = busy;
  assign unused_bid = ^M_BID;

  assign aw_hs      = M_AWVALID && M_AWREADY;
  assign b_hs       = M_BVALID && M_BREADY;
  assign fifo_empty = (fifo_cnt == '0);
  assign M_WVALID   = s_valid && !fifo_empty;
  assign M_WLAST    = M_WVALID && (beat_cnt == fifo_mem[rd_ptr]);
  assign w_hs       = M_WVALID && M_WREADY;
  assign s_ready    = w_hs;
  assign pop        = w_hs && M_WLAST;

  // 13-bit distance to the 4 KB page end, so offset 0 yields a full page of beats
  always_comb begin
    cand = MW'(MAX_BURST);
    bnd  = MW'((13'd4096 - {1'b0, addr[11:0]}) >> SZ);
    if (MW'(remaining) < cand) cand = MW'(remaining);
    if (bnd < cand) cand = bnd;
    len_calc = LW'(cand);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      len       <= '0;
      M_AWLEN   <= '0;
      M_AWVALID <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          addr      <= start_addr & ~ADDR_W'(DATA_W/8 - 1);
          remaining <= RW'(num_trans);
          err       <= 1'b0;
          if (num_trans == '0) done <= 1'b1;
          else begin
            busy  <= 1'b1;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          len <= len_calc;
          if (outstanding < OW'(MAX_OUTSTANDING)) begin
            M_AWLEN   <= 8'(len_calc - 9'd1);
            M_AWVALID <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: if (M_AWREADY) begin
          M_AWVALID <= 1'b0;
          addr      <= addr + (ADDR_W'(len) << SZ);
          remaining <= remaining - RW'(len);
          state     <= (remaining == RW'(len)) ? S_DRAIN : S_CALC;
        end
        S_DRAIN: if (fifo_empty && outstanding == '0) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (b_hs && M_BRESP != 2'b00) err <= 1'b1;
    end
  end

  // simultaneous AW and B handshakes cancel out
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) outstanding <= '0;
    else if (aw_hs && !b_hs) outstanding <= outstanding + 1'b1;
    else if (!aw_hs && b_hs) outstanding <= outstanding - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (aw_hs) fifo_mem[wr_ptr] <= M_AWLEN;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      if (aw_hs) wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)   rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
      if (aw_hs && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!aw_hs && pop) fifo_cnt <= fifo_cnt - 1'b1;
      if (w_hs) beat_cnt <= M_WLAST ? 8'd0 : beat_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_axi_dma_wr_mc.sv
// Self-checking bench for axi_dma_wr_mc: table of block transfers plus
// random slave stalls, scored against a burst-splitting reference model.
module tb_axi_dma_wr_mc;
  localparam int DW = 64;
  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] start_addr;
  logic [19:0] num_trans;
  logic [63:0] s_data;
  logic        s_valid, s_ready, busy, done, err;
  logic [3:0]  M_AWID;
  logic [31:0] M_AWADDR;
  logic [7:0]  M_AWLEN;
  logic [2:0]  M_AWSIZE;
  logic [1:0]  M_AWBURST;
  logic [3:0]  M_AWCACHE;
  logic [2:0]  M_AWPROT;
  logic [3:0]  M_AWQOS;
  logic        M_AWVALID, M_AWREADY;
  logic [63:0] M_WDATA;
  logic [7:0]  M_WSTRB;
  logic        M_WLAST, M_WVALID, M_WREADY;
  logic [3:0]  M_BID;
  logic [1:0]  M_BRESP;
  logic        M_BVALID, M_BREADY;

  axi_dma_wr_mc #(.DATA_W(DW), .ADDR_W(32), .ID_W(4), .MAX_BURST(16),
                  .MAX_OUTSTANDING(MO), .CNT_W(20), .AXI_ID(5)) dut (
    .clk(clk), .rstn(rstn), .start(start), .start_addr(start_addr),
    .num_trans(num_trans), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .busy(busy), .done(done), .err(err), .M_AWID(M_AWID), .M_AWADDR(M_AWADDR),
    .M_AWLEN(M_AWLEN), .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST),
    .M_AWCACHE(M_AWCACHE), .M_AWPROT(M_AWPROT), .M_AWQOS(M_AWQOS),
    .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY), .M_WDATA(M_WDATA),
    .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST), .M_WVALID(M_WVALID),
    .M_WREADY(M_WREADY), .M_BID(M_BID), .M_BRESP(M_BRESP),
    .M_BVALID(M_BVALID), .M_BREADY(M_BREADY));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference burst list and scoreboard state
  int unsigned exp_addr [64];
  int          exp_len  [64];
  int          exp_cnt;
  int aw_cnt, aw_beats, w_idx, w_in_burst, w_burst, b_cnt, pending_b, outst;
  int src_idx, aw_before_b, hold_cnt, bad_idx, last_aw_len;
  logic [31:0] last_aw_addr, aw_hold_addr;
  logic [7:0]  aw_hold_len;
  bit mon_en, rnd, bvalid_r, aw_wait;

  typedef struct {
    logic [31:0] addr;
    int          n;
    int          bad;
    bit          r;
    int          hold;
    int          exp_b;
    logic [31:0] exp_la;
    int          exp_ll;
    bit          exp_e;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input int i);
    return {32'(i) ^ 32'h5A5A0000, 32'(i * 13 + 1)};
  endfunction

  // split [addr, addr+n beats) into bursts: at most 16 beats, never past a 4 KB page
  task automatic build(input logic [31:0] a_in, input int n);
    int unsigned a = a_in & ~32'(DW/8 - 1);
    int rem = n;
    exp_cnt = 0;
    while (rem > 0) begin
      int l = 16;
      int page = (4096 - int'(a % 4096)) / (DW/8);
      if (rem < l) l = rem;
      if (page < l) l = page;
      exp_addr[exp_cnt] = a;
      exp_len[exp_cnt]  = l;
      exp_cnt++;
      a += l * (DW/8);
      rem -= l;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  // slave model and monitor: drive at negedge, sample before the next posedge
  initial begin
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        M_AWREADY = 1'b0; M_WREADY = 1'b0; s_valid = 1'b0; M_BVALID = 1'b0;
        M_BRESP = 2'b00; bvalid_r = 1'b0; aw_wait = 1'b0;
      end else begin
        M_AWREADY = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        M_WREADY  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_valid   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_data    = data_of(src_idx);
        if (hold_cnt > 0) hold_cnt--;
        if (!bvalid_r && pending_b > 0 && hold_cnt == 0 && (!rnd || $urandom_range(0, 1) == 1))
          bvalid_r = 1'b1;
        M_BVALID = bvalid_r;
        M_BRESP  = (b_cnt == bad_idx) ? 2'b10 : 2'b00;
        #1;
        if (aw_wait)
          check("aw_stable", {M_AWVALID, M_AWADDR, M_AWLEN}, {1'b1, aw_hold_addr, aw_hold_len});
        if (M_BVALID && M_BREADY) begin
          if (b_cnt == 0) aw_before_b = aw_cnt;
          b_cnt++; pending_b--; outst--;
          bvalid_r = 1'b0;
        end
        if (M_AWVALID && M_AWREADY) begin
          if (aw_cnt < exp_cnt) begin
            check("aw_addr", M_AWADDR, exp_addr[aw_cnt]);
            check("aw_len", M_AWLEN, exp_len[aw_cnt] - 1);
          end else check("aw_extra", aw_cnt, exp_cnt - 1);
          check("aw_const", {M_AWID, M_AWSIZE, M_AWBURST, M_AWCACHE, M_AWPROT, M_AWQOS},
                {4'd5, 3'd3, 2'b01, 4'b0011, 3'd0, 4'hF});
          last_aw_addr = M_AWADDR;
          last_aw_len  = M_AWLEN;
          aw_beats += int'(M_AWLEN) + 1;
          aw_cnt++; outst++;
          check("outstanding_max", outst <= MO, 1);
        end
        aw_wait      = M_AWVALID && !M_AWREADY;
        aw_hold_addr = M_AWADDR;
        aw_hold_len  = M_AWLEN;
        if ((M_WVALID && M_WREADY) || s_ready)
          check("s_ready", s_ready, M_WVALID && M_WREADY);
        if (M_WVALID && M_WREADY) begin
          bit exp_last;
          check("w_after_aw", w_idx < aw_beats, 1);
          check("w_data", M_WDATA, data_of(w_idx));
          check("w_strb", M_WSTRB, 8'hFF);
          exp_last = (w_burst < exp_cnt) && (w_in_burst == exp_len[w_burst] - 1);
          check("w_last", M_WLAST, exp_last);
          if (exp_last) begin
            w_burst++; w_in_burst = 0; pending_b++;
          end else w_in_burst++;
          w_idx++; src_idx++;
        end
      end
    end
  end

  task automatic clear_sb();
    aw_cnt = 0; aw_beats = 0; w_idx = 0; w_in_burst = 0; w_burst = 0; b_cnt = 0;
    pending_b = 0; outst = 0; src_idx = 0; aw_before_b = -1; last_aw_len = -1;
    last_aw_addr = '0;
  endtask

  task automatic run(input vec_t v);
    bit got = 1'b0;
    build(v.addr, v.n);
    clear_sb();
    rnd = v.r; bad_idx = v.bad; hold_cnt = v.hold; mon_en = 1'b1;
    start_addr = v.addr; num_trans = 20'(v.n); start = 1'b1;
    cyc();
    start = 1'b0;
    check("busy_c1", busy, 1);
    check("err_cleared", err, 0);
    check("awvalid_c1", M_AWVALID, 0);
    cyc();
    check("awvalid_c2", M_AWVALID, 1);
    for (int k = 0; k < 5000; k++) begin
      cyc();
      if (done) begin got = 1'b1; break; end
    end
    check("done_seen", got, 1);
    check("busy_at_done", busy, 0);
    check("err_at_done", err, v.exp_e);
    check("aw_count", aw_cnt, v.exp_b);
    check("last_aw_addr", last_aw_addr, v.exp_la);
    check("last_aw_len", last_aw_len, v.exp_ll);
    check("w_beats", w_idx, v.n);
    check("b_count", b_cnt, v.exp_b);
    if (v.hold > 0) check("aw_before_first_b", aw_before_b, MO);
    cyc();
    check("done_pulse", done, 0);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{32'h1000, 40, -1, 0, 0, 3, 32'h1100, 7, 0};
    vecs[1] = '{32'h0FC0, 16, -1, 0, 0, 2, 32'h1000, 7, 0};
    vecs[2] = '{32'h0000, 64, -1, 0, 50, 4, 32'h0180, 15, 0};
    vecs[3] = '{32'h2F00, 300, -1, 1, 0, 19, 32'h3800, 11, 0};
    vecs[4] = '{32'h1000, 40, 1, 0, 0, 3, 32'h1100, 7, 1};
    vecs[5] = '{32'h1000, 8, -1, 0, 0, 1, 32'h1000, 7, 0};
    vecs[6] = '{32'h1004, 3, -1, 0, 0, 1, 32'h1000, 2, 0};
    vecs[7] = '{32'h0FF8, 5, -1, 1, 0, 2, 32'h1000, 3, 0};

    rstn = 1'b0; start = 1'b0; start_addr = '0; num_trans = '0; s_data = '0;
    s_valid = 1'b0; M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BID = '0; M_BRESP = '0;
    M_BVALID = 1'b0; mon_en = 1'b0; rnd = 1'b0; bad_idx = -1; hold_cnt = 0;
    exp_cnt = 0; clear_sb();
    repeat (3) cyc();
    check("rst_outputs", {M_AWVALID, M_WVALID, M_WLAST, s_ready, busy, done, err, M_BREADY, M_AWADDR, M_AWLEN}, '0);
    check("rst_const", {M_AWID, M_AWSIZE, M_AWBURST, M_AWCACHE, M_AWPROT, M_AWQOS, M_WSTRB},
          {4'd5, 3'd3, 2'b01, 4'b0011, 3'd0, 4'hF, 8'hFF});
    rstn = 1'b1;
    cyc();

    // zero-length block: done next cycle, never busy, no AW
    start_addr = 32'h40; num_trans = '0; start = 1'b1;
    cyc();
    start = 1'b0;
    check("zero_done", {done, busy, M_AWVALID}, 3'b100);
    cyc();
    check("zero_after", {done, busy, M_AWVALID}, 3'b000);
    repeat (3) cyc();
    check("zero_no_aw", {busy, M_AWVALID}, 2'b00);

    for (int i = 0; i < 8; i++) run(vecs[i]);

    for (int i = 0; i < 4; i++) begin
      rv.addr = 32'h0001_0000 + 32'($urandom_range(0, 1023) * 8);
      rv.n    = int'($urandom_range(1, 120));
      rv.bad  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      rv.r    = 1'b1;
      rv.hold = 0;
      build(rv.addr, rv.n);
      rv.exp_b  = exp_cnt;
      rv.exp_la = exp_addr[exp_cnt - 1];
      rv.exp_ll = exp_len[exp_cnt - 1] - 1;
      rv.exp_e  = (rv.bad >= 0) && (rv.bad < exp_cnt);
      run(rv);
    end

    // reset in the middle of the second burst, then a clean restart
    build(32'h1000, 40);
    clear_sb();
    rnd = 1'b0; bad_idx = -1; hold_cnt = 0; mon_en = 1'b1;
    start_addr = 32'h1000; num_trans = 20'd40; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (aw_cnt >= 2) break;
      cyc();
    end
    check("mid_reached_2nd", aw_cnt >= 2, 1);
    repeat (3) cyc();
    rstn = 1'b0;
    mon_en = 1'b0;
    #1;
    check("mid_rst_outputs", {M_AWVALID, M_WVALID, M_WLAST, s_ready, busy, done, err, M_BREADY, M_AWADDR, M_AWLEN}, '0);
    cyc();
    check("mid_rst_held", {M_AWVALID, M_WVALID, busy, done}, 4'b0000);
    rstn = 1'b1;
    cyc();
    run(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_dma_wr_mc.md
Name: axi_dma_wr_mc

Overview:
- Next-generation AXI4 write-DMA master for the accelerator's parameter and result path.
- Accepts a streamed word source through a valid/ready handshake and splits a block of num_trans beats into INCR bursts. Each burst is limited by MAX_BURST, the remaining beat count and the 4 KB boundary.
- The AW and W channels are decoupled, so up to MAX_OUTSTANDING bursts can await BRESP at once.
- Reports completion and a sticky error flag to the layer controller.

Parameters:
- DATA_W, 32, AXI data width in bits; legal values 32, 64, 128.
- ADDR_W, 32, AXI address width.
- ID_W, 4, AXI ID width.
- MAX_BURST, 16, maximum beats per burst; power of 2, 1..256.
- MAX_OUTSTANDING, 4, maximum bursts with AW issued but B not yet received; power of 2, ≥1.
- CNT_W, 20, width of num_trans.
- AXI_ID, 0, constant AWID value.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle start pulse; ignored while busy=1
- start_addr  in  ADDR_W  byte address; low log2(DATA_W/8) bits are forced to 0
- num_trans  in  CNT_W  number of DATA_W beats to write
- s_data  in  DATA_W  source data
- s_valid  in  1  source data valid
- s_ready  out  1  source data accepted; equals M_WREADY && M_WVALID
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the block is complete
- err  out  1  sticky: at least one BRESP of the block was not OKAY; cleared on start
- M_AWID  out  ID_W  constant AXI_ID
- M_AWADDR  out  ADDR_W  burst address
- M_AWLEN  out  8  burst beats minus 1
- M_AWSIZE  out  3  log2(DATA_W/8)
- M_AWBURST  out  2  constant 2'b01 (INCR)
- M_AWCACHE  out  4  constant 4'b0011
- M_AWPROT  out  3  constant 0
- M_AWQOS  out  4  constant 4'hF
- M_AWVALID  out  1  address valid
- M_AWREADY  in  1  address ready
- M_WDATA  out  DATA_W  passes through s_data
- M_WSTRB  out  DATA_W/8  all ones
- M_WLAST  out  1  last beat of burst
- M_WVALID  out  1  write data valid
- M_WREADY  in  1  write data ready
- M_BID  in  ID_W  ignored
- M_BRESP  in  2  write response
- M_BVALID  in  1  response valid
- M_BREADY  out  1  response ready; tied high while busy

Behaviour:
- Reset: all outputs 0 and all counters 0. The FSM is IDLE and the length FIFO is empty. Constant AXI fields keep their constant values.
- Start: in IDLE, start latches addr, remaining=num_trans and err=0, and busy=1 from the next cycle.
  - If num_trans==0, done pulses on cycle +1 and busy stays 0; no AXI traffic is generated.
- AW FSM, states IDLE→CALC→ISSUE→(CALC|DRAIN)→IDLE:
  - CALC takes 1 cycle and registers len = min(MAX_BURST, remaining, (4096 − addr[11:0]) >> log2(DATA_W/8)).
  - ISSUE holds AWVALID with stable fields until AWREADY. Entry to ISSUE is gated on outstanding<MAX_OUTSTANDING.
  - On handshake, len is pushed to the length FIFO, addr += len·DATA_W/8, remaining −= len and outstanding++.
  - After the handshake the FSM returns to CALC if remaining>0; otherwise it goes to DRAIN.
  - Latency: start at cycle 0 gives the first AWVALID at cycle 2.
- W path: runs independently of AW.
  - M_WVALID = s_valid && length FIFO non-empty.
  - Data may be presented in the same cycle as, or after, its AW handshake; W never leads AW.
  - A beat counter compares against the FIFO head. WLAST is asserted on beat len−1, and the FIFO pops on the WLAST handshake.
  - s_ready is never asserted when the FIFO is empty.
- B path:
  - Each BVALID handshake decrements outstanding.
  - A non-OKAY BRESP sets err. The transfer continues to completion without abort or retry.
  - If AW and B handshakes occur in the same cycle, outstanding is unchanged.
- DRAIN: wait until the FIFO is empty and outstanding==0, then pulse done, drop busy and go to IDLE.
- Widths: internal beat arithmetic uses CNT_W+1 bits. Boundary computation uses 13 bits, so an aligned address at offset 0 gives 4096/bytes beats. Address wrap at 2^ADDR_W is not supported.
- Bursts never cross a 4 KB boundary.
- Reset mid-operation: everything returns to reset state immediately. In-flight AXI transactions are abandoned, and the system resets the interconnect alongside this block.

Test Plan:
- DATA_W=64, MAX_BURST=16, start_addr=0x1000, num_trans=40, slave always ready → AW 0x1000/LEN15, 0x1080/LEN15, 0x1100/LEN7. 40 W beats with WLAST on beats 16, 32 and 40; then done, err=0.
- start_addr=0x0FC0, num_trans=16, DATA_W=64 → AW 0x0FC0/LEN7 and 0x1000/LEN7; no burst crosses 0x1000.
- MAX_OUTSTANDING=2, BVALID held low for 50 cycles, num_trans=64, MAX_BURST=16 → exactly 2 AW handshakes until the first B, then the rest are issued; done only after the 4th B.
- Random s_valid and WREADY/AWREADY stalls over 300 beats → data order matches the source, AW fields stay stable while AWVALID is high, and no W beat precedes its AW.
- BRESP=SLVERR on the 2nd of 3 bursts → all 3 bursts still complete and done pulses with err=1. A following start clears err to 0.
- num_trans=0 → done at cycle +1 and no AWVALID. rstn low during the 2nd burst → all outputs 0 on the next edge, and a new start works normally.
